cp0_unit: RTL and testbench
===========================

Name: cp0_unit

Overview:
- Coprocessor 0 for the 5-stage MIPS pipeline. It is the consuming end of the exception tag carried through the stage registers.
- Sits at the M stage. It takes the ExcCode/BD/PC of the instruction at commit plus the 6 hardware interrupt lines.
- Drives req, which flushes every stage register and redirects fetch to the handler.
- Holds SR, Cause and EPC. Serves mtc0/mfc0 and restores state on eret.

Parameters:
- EXC_W, 5, width of exception code field; 0 = no exception
- HANDLER, 32'h0000_4180, exception entry PC driven on handler_pc

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high
- en  input  1  mtc0 write enable (M stage)
- addr  input  5  CP0 register number for mtc0/mfc0
- wdata  input  32  mtc0 write data
- rdata  output  32  mfc0 read data, combinational from addr
- M_PC  input  32  PC of the instruction in M
- M_ExcCode  input  EXC_W  exception code of the instruction in M
- M_BD  input  1  instruction in M sits in a branch delay slot
- HWInt  input  6  external interrupt lines, level-sensitive
- eret  input  1  eret at M
- req  output  1  take exception/interrupt this cycle (combinational)
- EPC_out  output  32  current EPC register value (eret target)
- handler_pc  output  32  constant HANDLER

Behaviour:
- Registers and fields:
  - SR (12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause (13): BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
  - EPC (14): 32 bits.
- Reset: SR=0, Cause=0, EPC=0. Therefore req=0 and EPC_out=0 after reset, and rdata=0 for every addr.
- int_req = |(HWInt & SR.IM) & SR.IE & ~SR.EXL
- exc_req = (M_ExcCode != 0) & ~SR.EXL
- req = int_req | exc_req. req is combinational, so the pipeline flush happens in the same cycle.
- Cause.IP <= HWInt every cycle unconditionally, including the req cycle. It is overridden only by reset.
- On a req edge:
  - SR.EXL <= 1.
  - Cause.BD <= M_BD.
  - Cause.ExcCode <= int_req ? 0 : M_ExcCode. Interrupt has priority over a simultaneous exception.
  - EPC <= M_BD ? M_PC-4 : M_PC, computed in 32-bit wrap-around arithmetic.
- mtc0 (en=1, req=0), by addr:
  - addr 12 writes IM, EXL, IE from the same bit positions of wdata.
  - addr 14 writes EPC = wdata, all 32 bits, no alignment.
  - addr 13 and any other addr: no effect.
- mtc0 with req=1 in the same cycle: the write is discarded and the exception update wins.
- eret with req=0: SR.EXL <= 0 at the edge. EPC_out is stable during that cycle, so fetch redirects to it.
- eret with req=1 cannot be legal because EXL=1 masks req. If it occurs anyway, the req update wins.
- mtc0 to SR plus eret in the same cycle: EXL ends 0, and the other SR fields take wdata.
- Masking:
  - While EXL=1, no nested req; further interrupts and exceptions are ignored.
  - An interrupt pending when EXL clears is taken on the first cycle EXL=0, provided IE=1 and IM matches.
- rdata: addr 12/13/14 return SR/Cause/EPC with unused bits 0. Any other addr returns 0.
- rdata reflects register state before the current edge; there is no write-through.
- Reset mid-exception: the next edge clears everything, and req falls combinationally once SR=0.

Test Plan:
- Reset: after reset, mfc0 addr 12/13/14 -> all 0, req=0. Then HWInt=6'b000001 with SR=0 -> req stays 0 and Cause reads 32'h0000_0400.
- Exception not in delay slot: M_PC=32'h3010, M_ExcCode=12, M_BD=0, EXL=0 -> req=1 same cycle. Next cycle: EPC=32'h3010, Cause=32'h0000_0030, SR.EXL=1, req=0 while M_ExcCode stays 12.
- Delay-slot exception: M_PC=32'h3020, M_ExcCode=4, M_BD=1 -> EPC=32'h301C and Cause[31]=1 with ExcCode=4. Then eret -> EXL=0 next cycle and EPC_out=32'h301C.
- Interrupt vs exception: mtc0 SR=32'h0000_0401, then HWInt=6'b000001 with M_ExcCode=10 in the same cycle -> req=1 and Cause.ExcCode=0. With IM=0 instead -> ExcCode=10.
- mtc0/req conflict: en=1, addr=14, wdata=32'hDEAD_BEEF, with M_ExcCode=8 at M_PC=32'h3000 -> EPC=32'h3000, not DEADBEEF. Repeat with ExcCode=0 -> EPC=32'hDEAD_BEEF. Write to addr 13 -> Cause unchanged.
- Pending interrupt after eret: EXL=1, IE=1, IM[0]=1, HWInt[0]=1 held -> req=0 until eret. On the cycle after the eret edge req=1, and EPC captures that cycle's M_PC.

Source files
------------

// File: rtl/cp0_if.sv
// CP0 pipeline-side bundle: mtc0/mfc0 access, commit-stage exception tag,
// interrupt lines, and the redirect outputs back to fetch.
interface cp0_if #(
    parameter int unsigned EXC_W = 5
);
    logic             en;
    logic [4:0]       addr;
    logic [31:0]      wdata;
    logic [31:0]      rdata;
    logic [31:0]      M_PC;
    logic [EXC_W-1:0] M_ExcCode;
    logic             M_BD;
    logic [5:0]       HWInt;
    logic             eret;
    logic             req;
    logic [31:0]      EPC_out;
    logic [31:0]      handler_pc;

    modport master (
        output en, addr, wdata, M_PC, M_ExcCode, M_BD, HWInt, eret,
        input  rdata, req, EPC_out, handler_pc
    );

    modport slave (
        input  en, addr, wdata, M_PC, M_ExcCode, M_BD, HWInt, eret,
        output rdata, req, EPC_out, handler_pc
    );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor 0 at the M stage: holds SR/Cause/EPC, raises the flush/redirect
// request for interrupts and exceptions, and restores EXL on eret.
module cp0_unit #(
    parameter int unsigned EXC_W   = 5,
    parameter logic [31:0] HANDLER = 32'h0000_4180
) (
    input logic  clk,
    input logic  reset,
    cp0_if.slave bus
);
    localparam logic [4:0]  A_SR    = 5'd12;
    localparam logic [4:0]  A_CAUSE = 5'd13;
    localparam logic [4:0]  A_EPC   = 5'd14;
    localparam int unsigned CODE_W  = 5;

    logic [5:0]        r_im;
    logic              r_exl;
    logic              r_ie;
    logic              r_bd;
    logic [5:0]        r_ip;
    logic [CODE_W-1:0] r_exc;
    logic [31:0]       r_epc;

    logic              w_int_req;
    logic              w_exc_req;
    logic              w_req;
    logic              w_wr_sr;
    logic              w_wr_epc;
    logic [31:0]       w_epc_next;
    logic [31:0]       w_sr;
    logic [31:0]       w_cause;

    // EXL masks both sources so no request can nest inside a handler
    assign w_int_req  = (|(bus.HWInt & r_im)) & r_ie & ~r_exl;
    assign w_exc_req  = (bus.M_ExcCode != EXC_W'(0)) & ~r_exl;
    assign w_req      = w_int_req | w_exc_req;

    assign w_wr_sr    = bus.en & (bus.addr == A_SR);
    assign w_wr_epc   = bus.en & (bus.addr == A_EPC);
    assign w_epc_next = bus.M_BD ? (bus.M_PC - 32'd4) : bus.M_PC;

    assign w_sr       = {16'b0, r_im, 8'b0, r_exl, r_ie};
    assign w_cause    = {r_bd, 15'b0, r_ip, 3'b0, r_exc, 2'b0};

    // Status: exception entry beats mtc0; eret clears EXL after any mtc0 SR write
    always_ff @(posedge clk) begin
        if (reset) begin
            r_im  <= 6'b0;
            r_exl <= 1'b0;
            r_ie  <= 1'b0;
        end else if (w_req) begin
            r_exl <= 1'b1;
        end else begin
            if (w_wr_sr) begin
                r_im <= bus.wdata[15:10];
                r_ie <= bus.wdata[0];
            end
            if (bus.eret) begin
                r_exl <= 1'b0;
            end else if (w_wr_sr) begin
                r_exl <= bus.wdata[1];
            end
        end
    end

    // Cause: IP tracks the lines every cycle; BD/ExcCode latch on entry only
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ip  <= 6'b0;
            r_bd  <= 1'b0;
            r_exc <= '0;
        end else begin
            r_ip <= bus.HWInt;
            if (w_req) begin
                r_bd  <= bus.M_BD;
                r_exc <= w_int_req ? CODE_W'(0) : CODE_W'(bus.M_ExcCode);
            end
        end
    end

    // EPC: restart point is the branch when the faulting op is in its delay slot
    always_ff @(posedge clk) begin
        if (reset) begin
            r_epc <= 32'b0;
        end else if (w_req) begin
            r_epc <= w_epc_next;
        end else if (w_wr_epc) begin
            r_epc <= bus.wdata;
        end
    end

    // mfc0 read mux, pre-edge state
    always_comb begin
        bus.rdata = 32'b0;
        case (bus.addr)
            A_SR:    bus.rdata = w_sr;
            A_CAUSE: bus.rdata = w_cause;
            A_EPC:   bus.rdata = r_epc;
            default: bus.rdata = 32'b0;
        endcase
    end

    assign bus.req        = w_req;
    assign bus.EPC_out    = r_epc;
    assign bus.handler_pc = HANDLER;

endmodule

// File: tb/tb_cp0_unit.sv
// Bench for cp0_unit: word-level register model checked every cycle, plus
// directed vectors with hand-computed literal expectations.
module tb_cp0_unit;
    logic clk;
    logic reset;

    cp0_if #(.EXC_W(5)) bus ();

    cp0_unit #(.EXC_W(5), .HANDLER(32'h0000_4180)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state as architectural 32-bit words
    logic [31:0] m_sr, m_cause, m_epc;
    logic [31:0] n_sr, n_cause, n_epc;
    logic        m_valid = 1'b0;
    logic        m_int, m_exc, m_req;

    assign m_int = ((bus.HWInt & m_sr[15:10]) != 6'b0) && m_sr[0] && !m_sr[1];
    assign m_exc = (bus.M_ExcCode != 5'd0) && !m_sr[1];
    assign m_req = m_int || m_exc;

    always_comb begin
        n_sr    = m_sr;
        n_cause = {m_cause[31:16], bus.HWInt, m_cause[9:0]};
        n_epc   = m_epc;
        if (m_req) begin
            n_sr        = m_sr | 32'h0000_0002;
            n_cause[31] = bus.M_BD;
            n_cause[6:2] = m_int ? 5'd0 : bus.M_ExcCode;
            n_epc       = bus.M_PC - (bus.M_BD ? 32'd4 : 32'd0);
        end else begin
            if (bus.en && bus.addr == 5'd12) n_sr  = bus.wdata & 32'h0000_FC03;
            if (bus.en && bus.addr == 5'd14) n_epc = bus.wdata;
            if (bus.eret) n_sr = n_sr & ~32'h0000_0002;
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            m_sr    <= 32'b0;
            m_cause <= 32'b0;
            m_epc   <= 32'b0;
            m_valid <= 1'b1;
        end else begin
            m_sr    <= n_sr;
            m_cause <= n_cause;
            m_epc   <= n_epc;
        end
    end

    function automatic logic [31:0] model_rd(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            default: return 32'b0;
        endcase
    endfunction

    // Literal expectations posted by the stimulus for the current cycle
    logic        lit_rd_on = 1'b0, lit_req_on = 1'b0, lit_epc_on = 1'b0;
    logic [31:0] lit_rd, lit_epc;
    logic        lit_req;
    string       lit_name = "";

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_req",   {31'b0, bus.req}, {31'b0, m_req});
            chk("model_rdata", bus.rdata, model_rd(bus.addr));
            chk("model_epc",   bus.EPC_out, m_epc);
            chk("handler_pc",  bus.handler_pc, 32'h0000_4180);
        end
        if (lit_rd_on)  chk({lit_name, "_rdata"}, bus.rdata, lit_rd);
        if (lit_req_on) chk({lit_name, "_req"}, {31'b0, bus.req}, {31'b0, lit_req});
        if (lit_epc_on) chk({lit_name, "_epc"}, bus.EPC_out, lit_epc);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        lit_rd_on  = 1'b0;
        lit_req_on = 1'b0;
        lit_epc_on = 1'b0;
        bus.en     = 1'b0;
        bus.eret   = 1'b0;
    endtask

    task automatic exp_rd(input string n, input logic [4:0] a, input logic [31:0] v);
        lit_name = n; bus.addr = a; lit_rd = v; lit_rd_on = 1'b1;
    endtask

    task automatic exp_req(input string n, input logic v);
        lit_name = n; lit_req = v; lit_req_on = 1'b1;
    endtask

    task automatic exp_epc(input string n, input logic [31:0] v);
        lit_name = n; lit_epc = v; lit_epc_on = 1'b1;
    endtask

    task automatic exc(input logic [31:0] pc, input logic [4:0] code, input logic bd);
        bus.M_PC = pc; bus.M_ExcCode = code; bus.M_BD = bd;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.en = 1'b1; bus.addr = a; bus.wdata = d;
    endtask

    initial begin
        reset = 1'b1;
        bus.en = 1'b0; bus.addr = 5'd0; bus.wdata = 32'b0; bus.eret = 1'b0;
        bus.HWInt = 6'b0;
        exc(32'h0, 5'd0, 1'b0);
        cyc(); cyc();
        reset = 1'b0;

        // Reset state
        exp_rd("rst_sr", 5'd12, 32'h0); exp_req("rst", 1'b0); cyc();
        exp_rd("rst_cause", 5'd13, 32'h0); cyc();
        exp_rd("rst_epc", 5'd14, 32'h0); exp_epc("rst", 32'h0); cyc();
        bus.HWInt = 6'b000001; exp_req("int_masked", 1'b0); cyc();
        exp_rd("ip_track", 5'd13, 32'h0000_0400); cyc();
        bus.HWInt = 6'b0; cyc();

        // Plain exception
        exc(32'h3010, 5'd12, 1'b0); exp_req("exc12", 1'b1); cyc();
        exp_req("exl_mask", 1'b0); exp_rd("exc12_epc", 5'd14, 32'h3010); cyc();
        exp_rd("exc12_cause", 5'd13, 32'h0000_0030); cyc();
        exp_rd("exc12_sr", 5'd12, 32'h0000_0002); cyc();
        exc(32'h3014, 5'd0, 1'b0); bus.eret = 1'b1; cyc();
        exp_rd("eret1_sr", 5'd12, 32'h0); cyc();

        // Delay-slot exception
        exc(32'h3020, 5'd4, 1'b1); exp_req("ds_exc", 1'b1); cyc();
        exc(32'h3024, 5'd0, 1'b0);
        exp_rd("ds_epc", 5'd14, 32'h301C); cyc();
        exp_rd("ds_cause", 5'd13, 32'h8000_0010); cyc();
        bus.eret = 1'b1; exp_epc("ds_eret", 32'h301C); cyc();
        exp_rd("ds_eret_sr", 5'd12, 32'h0); exp_epc("ds_after", 32'h301C); cyc();

        // Interrupt beats simultaneous exception
        mtc0(5'd12, 32'h0000_0401); cyc();
        bus.HWInt = 6'b000001; exc(32'h3040, 5'd10, 1'b0); exp_req("int_pri", 1'b1); cyc();
        bus.HWInt = 6'b0; exc(32'h3044, 5'd0, 1'b0);
        exp_rd("int_pri_cause", 5'd13, 32'h0000_0400); cyc();
        bus.eret = 1'b1; cyc();
        mtc0(5'd12, 32'h0000_0001); cyc();
        bus.HWInt = 6'b000001; exc(32'h3048, 5'd10, 1'b0); exp_req("im0_exc", 1'b1); cyc();
        bus.HWInt = 6'b0; exc(32'h304C, 5'd0, 1'b0);
        exp_rd("im0_cause", 5'd13, 32'h0000_0428); cyc();
        bus.eret = 1'b1; cyc();

        // mtc0 vs exception on the same edge
        mtc0(5'd14, 32'hDEAD_BEEF); exc(32'h3000, 5'd8, 1'b0); exp_req("conf", 1'b1); cyc();
        exc(32'h3004, 5'd0, 1'b0);
        exp_rd("conf_epc", 5'd14, 32'h3000); cyc();
        bus.eret = 1'b1; cyc();
        mtc0(5'd14, 32'hDEAD_BEEF); exp_req("wr_epc", 1'b0); cyc();
        exp_rd("wr_epc", 5'd14, 32'hDEAD_BEEF); exp_epc("wr_epc", 32'hDEAD_BEEF); cyc();
        mtc0(5'd13, 32'hFFFF_FFFF); cyc();
        exp_rd("cause_ro", 5'd13, 32'h0000_0020); cyc();
        exp_rd("addr0", 5'd0, 32'h0); cyc();
        exp_rd("addr31", 5'd31, 32'h0); cyc();

        // Interrupt pending across EXL, taken right after eret
        mtc0(5'd12, 32'h0000_0403); cyc();
        bus.HWInt = 6'b000001; exp_req("pend0", 1'b0); cyc();
        exp_req("pend1", 1'b0); cyc();
        bus.eret = 1'b1; exc(32'h3050, 5'd0, 1'b0); exp_req("pend_eret", 1'b0); cyc();
        exc(32'h3054, 5'd0, 1'b0); exp_req("pend_take", 1'b1); cyc();
        bus.HWInt = 6'b0;
        exp_rd("pend_epc", 5'd14, 32'h3054); cyc();

        // Reset while EXL is set
        bus.HWInt = 6'b000001; reset = 1'b1; cyc();
        reset = 1'b0;
        exp_rd("rst2_sr", 5'd12, 32'h0); exp_req("rst2", 1'b0); cyc();
        exp_rd("rst2_epc", 5'd14, 32'h0); cyc();
        bus.HWInt = 6'b0; cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
